// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder with a loadable byte array.
// Serves 0x03 reads, 0x9F JEDEC ID and 0x05 status.
module spi_flash_responder #(
  parameter int          MEM_BITS = 12,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_cs,
  input  logic                spi_clk,
  input  logic                spi_di,
  output logic                spi_do,
  input  logic                load_we,
  input  logic [MEM_BITS-1:0] load_addr,
  input  logic [7:0]          load_data,
  output logic                active,
  output logic                cmd_valid,
  output logic [7:0]          cmd
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, IGNORE
  } state_t;

  typedef enum logic [1:0] {
    SRC_MEM, SRC_ID, SRC_STAT
  } src_t;

  logic [7:0] mem [0:(1<<MEM_BITS)-1];

  state_t              state_q, state_d;
  src_t                src_q, src_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic [2:0]          txcnt_q, txcnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          sh_q, sh_d;
  logic [7:0]          out_q, out_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [MEM_BITS-1:0] ptr_q, ptr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                do_q, do_d;
  logic                active_q, active_d;
  logic [7:0]          rdata_q;
  logic [7:0]          cur;

  logic cs_m_q, cs_s_q, cs_p_q;
  logic sclk_m_q, sclk_s_q, sclk_p_q;
  logic di_m_q, di_s_q;
  logic cs_fall, sclk_rise, sclk_fall;

  // Synchronize SPI pins; cs_p starts low so only a real high-to-low is an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_m_q   <= 1'b0;
      cs_s_q   <= 1'b0;
      cs_p_q   <= 1'b0;
      sclk_m_q <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_p_q <= 1'b0;
      di_m_q   <= 1'b0;
      di_s_q   <= 1'b0;
    end else begin
      cs_m_q   <= spi_cs;
      cs_s_q   <= cs_m_q;
      cs_p_q   <= cs_s_q;
      sclk_m_q <= spi_clk;
      sclk_s_q <= sclk_m_q;
      sclk_p_q <= sclk_s_q;
      di_m_q   <= spi_di;
      di_s_q   <= di_m_q;
    end
  end

  assign cs_fall   = cs_p_q & ~cs_s_q;
  assign sclk_rise = sclk_s_q & ~sclk_p_q;
  assign sclk_fall = ~sclk_s_q & sclk_p_q;

  // Byte array: one-cycle read, read returns old data on a same-cycle write.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    rdata_q <= mem[ptr_q];
  end

  // Select the byte currently being served.
  always_comb begin
    cur = 8'h00;
    unique case (src_q)
      SRC_MEM: cur = rdata_q;
      SRC_ID: begin
        unique case (idx_q)
          2'd0:    cur = JEDEC_ID[23:16];
          2'd1:    cur = JEDEC_ID[15:8];
          2'd2:    cur = JEDEC_ID[7:0];
          default: cur = 8'h00;
        endcase
      end
      default: cur = 8'h00;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= SRC_STAT;
      bitcnt_q    <= '0;
      txcnt_q     <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      out_q       <= '0;
      cmd_q       <= '0;
      ptr_q       <= '0;
      cmd_valid_q <= 1'b0;
      do_q        <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      bitcnt_q    <= bitcnt_d;
      txcnt_q     <= txcnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      out_q       <= out_d;
      cmd_q       <= cmd_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      do_q        <= do_d;
      active_q    <= active_d;
    end
  end

  // Next-state logic: cs high always wins and returns to IDLE.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    bitcnt_d    = bitcnt_q;
    txcnt_d     = txcnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    out_d       = out_q;
    cmd_d       = cmd_q;
    ptr_d       = ptr_q;
    cmd_valid_d = 1'b0;
    do_d        = do_q;
    active_d    = active_q;
    if (cs_s_q) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      txcnt_d  = '0;
      ptr_d    = '0;
      do_d     = 1'b0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          do_d = 1'b0;
          if (cs_fall) begin
            state_d  = CMD;
            bitcnt_d = '0;
            active_d = 1'b1;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            sh_d     = {sh_q[6:0], di_s_q};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              cmd_d       = sh_d;
              cmd_valid_d = 1'b1;
              bitcnt_d    = '0;
              txcnt_d     = '0;
              idx_d       = '0;
              ptr_d       = '0;
              unique case (sh_d)
                8'h03: state_d = ADDR;
                8'h9F: begin
                  state_d = DATA;
                  src_d   = SRC_ID;
                end
                8'h05: begin
                  state_d = DATA;
                  src_d   = SRC_STAT;
                end
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            ptr_d    = {ptr_q[MEM_BITS-2:0], di_s_q};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              state_d  = DATA;
              src_d    = SRC_MEM;
              bitcnt_d = '0;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            if (txcnt_q == 3'd0) begin
              do_d  = cur[7];
              out_d = {cur[6:0], 1'b0};
            end else begin
              do_d  = out_q[7];
              out_d = {out_q[6:0], 1'b0};
            end
            txcnt_d = txcnt_q + 3'd1;
            if (txcnt_q == 3'd7) begin
              ptr_d = ptr_q + 1'b1;
              if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
            end
          end
        end
        default: do_d = 1'b0;
      endcase
    end
  end

  assign spi_do    = do_q & (state_q == DATA);
  assign active    = active_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter MEM_BITS, 12, log2 of internal byte-array depth (4096 bytes).
REQ-002 SHALL have parameter JEDEC_ID, 24'hEF4018, ID bytes returned by command 0x9F, MSB first.

Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk, input, 1, system clock; reset is synchronous, active-high.
REQ-004 SHALL have port reset, input, 1, reset signal, synchronous, active-high.
REQ-005 SHALL have port spi_cs, input, 1, chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_clk, input, 1, SPI clock from initiator, asynchronous to clk.
REQ-007 SHALL have port spi_di, input, 1, initiator-to-responder serial data.
REQ-008 SHALL have port spi_do, output, 1, responder-to-initiator serial data.
REQ-009 SHALL have port load_we, input, 1, byte-array write strobe.
REQ-010 SHALL have port load_addr, input, MEM_BITS, byte-array write address.
REQ-011 SHALL have port load_data, input, 8, byte-array write data.
REQ-012 SHALL have port active, output, 1, high while synchronized spi_cs is low.
REQ-013 SHALL have port cmd_valid, output, 1, one-clk pulse when a command byte completes.
REQ-014 SHALL have port cmd, output, 8, last completed command byte; held until the next one.

Function
REQ-015 SHALL pass spi_cs, spi_clk and spi_di each through a 2-FF synchronizer, then detect spi_clk edges on the synchronized signal; supported spi_clk high and low times are >= 4 clk.
REQ-016 SHALL operate in SPI mode 0: sample spi_di on rising spi_clk; update spi_do on falling spi_clk.
REQ-017 SHALL implement states IDLE, CMD, ADDR, DATA, IGNORE.
REQ-018 IDLE -> CMD on synchronized spi_cs falling; bit counter cleared.
REQ-019 CMD: shift 8 bits MSB first; on 8th rising edge, cmd <= byte and cmd_valid pulses 1 clk.
REQ-020 Byte 0x03 -> ADDR; 0x9F -> DATA, serving JEDEC_ID bytes then 0x00 forever; 0x05 -> DATA, serving status 0x00 repeatedly; any other byte -> IGNORE.
REQ-021 ADDR: shift 24 bits MSB first into a pointer; after the 24th rising edge -> DATA, serving the array at pointer[MEM_BITS-1:0]; upper bits are ignored.
REQ-022 DATA: on the falling edge following the last sampled command/address bit, drive bit 7 of the first byte; each later falling edge drives the next bit, MSB first.
REQ-023 DATA: after bit 0 of each byte is shifted out, load the next byte; the pointer increments modulo 2^MEM_BITS, so reading past the array top wraps to 0.
REQ-024 IGNORE: spi_do = 0; stay until spi_cs rises.
REQ-025 Synchronized spi_cs rising in any state, including mid-byte, SHALL force IDLE within 1 clk, clear bit count and pointer, and set spi_do = 0.
REQ-026 spi_do SHALL be 0 whenever state is not DATA.
REQ-027 load_we writes load_data to load_addr on the same clk edge, in any state.
REQ-028 If load_we targets the byte currently being fetched, the fetched value is the old contents; the next read returns the new value.
REQ-029 Byte-array read latency SHALL be 1 clk (block RAM inferable); fetch completes before the next falling spi_clk given REQ-015 timing.
REQ-030 A spi_clk edge while synchronized spi_cs is high SHALL be ignored.

Reset
REQ-031 On reset: state IDLE, spi_do 0, active 0, cmd_valid 0, cmd 8'h00, pointer 0, bit counter 0.
REQ-032 Reset SHALL NOT clear byte-array contents.
REQ-033 Reset asserted mid-transaction SHALL abort it; the responder stays in IDLE until a new spi_cs falling edge arrives after reset deasserts.

Verification
REQ-034 Preload bytes 0x000..0x003 = 11,22,33,44; send 03 00 00 00, clock 32 bits -> 11 22 33 44 on spi_do; cmd_valid pulses once with cmd=03.
REQ-035 Preload 0xFFF=AA, 0x000=55; send 03 12 3F FF, clock 16 bits -> AA 55 (wrap; upper address bits ignored).
REQ-036 Send 9F, clock 32 bits -> EF 40 18 00.
REQ-037 Send 03 00 00 10, raise spi_cs after 3 data bits, then send 05 with 8 clocks -> first transfer aborts; status returns 00; spi_do = 0 between transfers.
REQ-038 Send A5 and clock 16 bits -> spi_do stays 0; cmd=A5.
REQ-039 Assert reset during ADDR phase -> all outputs at reset values next clk; array contents intact; a new 03 read returns the preloaded data.
